amp_pwr_seq: RTL and testbench

Parametrised power-sequencing and fault-recovery controller for N class-D amplifier channels in the Equalizer design. It holds each amp in shutdown for a fixed time after reset, filters the amp's active-low fault line, and cycles the amp through timed shutdown/retry on a fault. After a set number of retries it locks the amp out until software clears it. A global `mute` tells the speaker drivers to stay silent while any amp is not running.

---
 rtl/amp_pwr_seq_pkg.sv | 24 ++
 rtl/amp_pwr_seq_if.sv | 12 +
 rtl/amp_pwr_seq_chan_fsm.sv | 90 +++++++++
 rtl/amp_pwr_seq.sv | 43 ++++
 tb/tb_amp_pwr_seq.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/amp_pwr_seq_pkg.sv
// Shared types and defaults for the amplifier power sequencer.
package amp_pwr_seq_pkg;

  typedef enum logic [1:0] {
    SHDN = 2'd0,
    RUN  = 2'd1,
    FLT  = 2'd2,
    LOCK = 2'd3
  } chan_state_t;

  localparam int DEF_NUM_AMP   = 2;
  localparam int DEF_SHDN_CYC  = 250000;
  localparam int DEF_FILT_CYC  = 16;
  localparam int DEF_MAX_RETRY = 3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/amp_pwr_seq_if.sv
// Amp control/status bundle: fault inputs, clear pulse and sequencer outputs.
interface amp_pwr_seq_if #(parameter int NUM_AMP = 2);
  logic [NUM_AMP-1:0] Flt_n;
  logic               clr_flt;
  logic [NUM_AMP-1:0] sht_dwn;
  logic [NUM_AMP-1:0] amp_rdy;
  logic [NUM_AMP-1:0] lockout;
  logic               mute;

  modport master (output Flt_n, clr_flt, input sht_dwn, amp_rdy, lockout, mute);
  modport slave  (input Flt_n, clr_flt, output sht_dwn, amp_rdy, lockout, mute);
endinterface

// File: rtl/amp_pwr_seq_chan_fsm.sv
// One amplifier channel: fault synchronizer/filter, hold timer, retry count, FSM.
module amp_chan_fsm
  import amp_pwr_seq_pkg::*;
#(
  parameter int SHDN_CYC  = DEF_SHDN_CYC,
  parameter int FILT_CYC  = DEF_FILT_CYC,
  parameter int MAX_RETRY = DEF_MAX_RETRY
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flt_n,
  input  logic clr_flt,
  output logic sht_dwn,
  output logic amp_rdy,
  output logic lockout
);

  localparam int TW = clog2(SHDN_CYC + 1);
  localparam int FW = (FILT_CYC > 1) ? clog2(FILT_CYC) : 1;
  localparam logic [TW-1:0] T_END = TW'(SHDN_CYC - 1);
  localparam logic [FW-1:0] F_END = FW'(FILT_CYC - 1);
  localparam logic [2:0]    R_MAX = 3'(MAX_RETRY);

  chan_state_t   state, nxt;
  logic [1:0]    sync;
  logic [TW-1:0] tmr;
  logic [FW-1:0] filt;
  logic [2:0]    retry, retry_inc;
  logic          flt_low, tmr_done, filt_done;

  assign flt_low   = ~sync[1];
  assign tmr_done  = (tmr == T_END);
  assign filt_done = flt_low && (filt == F_END);
  // A clear arriving with FLT expiry takes effect before the increment.
  assign retry_inc = (clr_flt ? 3'd0 : retry) + 3'd1;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= SHDN;
    else        state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      SHDN: if (tmr_done)  nxt = RUN;
      RUN:  if (filt_done) nxt = FLT;
      FLT:  if (tmr_done)  nxt = (retry_inc == R_MAX) ? LOCK : RUN;
      LOCK: if (clr_flt)   nxt = SHDN;
      default:             nxt = SHDN;
    endcase
  end

  logic sd_d, rdy_d, lk_d;
  always_comb begin
    sd_d  = (nxt != RUN);
    rdy_d = (nxt == RUN);
    lk_d  = (nxt == LOCK);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sht_dwn <= 1'b1;
      amp_rdy <= 1'b0;
      lockout <= 1'b0;
    end else begin
      sht_dwn <= sd_d;
      amp_rdy <= rdy_d;
      lockout <= lk_d;
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync <= 2'b11;
    else        sync <= {sync[0], flt_n};

  // Timer restarts on every state change and saturates once RUN is long enough.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                               tmr <= '0;
    else if (nxt != state || state == LOCK)   tmr <= '0;
    else if (!tmr_done)                       tmr <= tmr + 1'b1;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                                       filt <= '0;
    else if (state == RUN && nxt == RUN && flt_low)   filt <= filt + 1'b1;
    else                                              filt <= '0;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                                    retry <= 3'd0;
    else if (state == FLT && tmr_done)             retry <= retry_inc;
    else if (clr_flt || (state == RUN && tmr_done)) retry <= 3'd0;

endmodule

// File: rtl/amp_pwr_seq.sv
// Power sequencer top: NUM_AMP channel FSMs plus the registered global mute.
module amp_pwr_seq
  import amp_pwr_seq_pkg::*;
#(
  parameter int NUM_AMP   = DEF_NUM_AMP,
  parameter int SHDN_CYC  = DEF_SHDN_CYC,
  parameter int FILT_CYC  = DEF_FILT_CYC,
  parameter int MAX_RETRY = DEF_MAX_RETRY
) (
  input logic           clk,
  input logic           rst_n,
  amp_pwr_seq_if.slave  bus
);

  logic [NUM_AMP-1:0] sd, rdy, lk;
  logic               mute_q;

  for (genvar g = 0; g < NUM_AMP; g++) begin : g_chan
    amp_chan_fsm #(
      .SHDN_CYC  (SHDN_CYC),
      .FILT_CYC  (FILT_CYC),
      .MAX_RETRY (MAX_RETRY)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .flt_n   (bus.Flt_n[g]),
      .clr_flt (bus.clr_flt),
      .sht_dwn (sd[g]),
      .amp_rdy (rdy[g]),
      .lockout (lk[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mute_q <= 1'b1;
    else        mute_q <= |(~rdy);

  assign bus.sht_dwn = sd;
  assign bus.amp_rdy = rdy;
  assign bus.lockout = lk;
  assign bus.mute    = mute_q;

endmodule

// File: tb/tb_amp_pwr_seq.sv
// Bench for amp_pwr_seq: scheduled-expectation scoreboard, fault-pulse table and corner sequences.
module tb_amp_pwr_seq;
  localparam int SHDN = 100;
  localparam int SD = 0, RDY = 1, LK = 2, MU = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  amp_pwr_seq_if #(.NUM_AMP(2)) bus ();

  amp_pwr_seq #(.NUM_AMP(2), .SHDN_CYC(SHDN), .FILT_CYC(4), .MAX_RETRY(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct { string name; int due; int sel; logic [7:0] exp; } chk_t;
  chk_t sb[$];

  typedef struct { string name; int amp; int len; bit hit; } row_t;
  row_t rows[7];

  task automatic push_chk(input string nm, input int dly, input int sel, input logic [7:0] e);
    chk_t c;
    c.name = nm; c.due = cyc + dly; c.sel = sel; c.exp = e;
    sb.push_back(c);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expectations fire on the falling edge of the cycle they were scheduled for.
  always @(negedge clk) begin
    logic [7:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        case (sb[i].sel)
          SD:      act = {6'd0, bus.sht_dwn};
          RDY:     act = {6'd0, bus.amp_rdy};
          LK:      act = {6'd0, bus.lockout};
          default: act = {7'd0, bus.mute};
        endcase
        checks++;
        if (act !== sb[i].exp) begin
          errors++;
          $display("FAIL %s: got %0h expected %0h at cycle %0d", sb[i].name, act, sb[i].exp, cyc);
        end
        sb.delete(i);
      end
    end
  end

  task automatic powerup_checks(input string tag);
    push_chk({tag, "_sd_e1"},    1,   SD,  8'd3);
    push_chk({tag, "_sd_e99"},   99,  SD,  8'd3);
    push_chk({tag, "_rdy_e99"},  99,  RDY, 8'd0);
    push_chk({tag, "_sd_e100"},  100, SD,  8'd0);
    push_chk({tag, "_rdy_e100"}, 100, RDY, 8'd3);
    push_chk({tag, "_mute_e100"},100, MU,  8'd1);
    push_chk({tag, "_mute_e101"},101, MU,  8'd0);
    tick(110);
  endtask

  task automatic reset_checks(input string tag);
    push_chk({tag, "_sd"},   0, SD,  8'd3);
    push_chk({tag, "_rdy"},  0, RDY, 8'd0);
    push_chk({tag, "_lk"},   0, LK,  8'd0);
    push_chk({tag, "_mute"}, 0, MU,  8'd1);
  endtask

  task automatic clr_pulse();
    bus.clr_flt = 1'b1;
    tick(1);
    bus.clr_flt = 1'b0;
    tick(3);
  endtask

  initial begin
    logic [1:0] fv;
    logic [7:0] bitv;
    rows[0] = '{"a0_len1", 0, 1, 1'b0};
    rows[1] = '{"a0_len3", 0, 3, 1'b0};
    rows[2] = '{"a0_len4", 0, 4, 1'b1};
    rows[3] = '{"a1_len3", 1, 3, 1'b0};
    rows[4] = '{"a1_len4", 1, 4, 1'b1};
    rows[5] = '{"a0_len9", 0, 9, 1'b1};
    rows[6] = '{"a1_len2", 1, 2, 1'b0};

    bus.Flt_n = 2'b11;
    bus.clr_flt = 1'b0;
    tick(2);
    reset_checks("rst");
    tick(2);
    rst_n = 1'b1;
    powerup_checks("pu");

    // Fault pulses on one amp while both run; only pulses of 4+ cycles trip it.
    for (int r = 0; r < 7; r++) begin
      bitv = 8'd1 << rows[r].amp;
      push_chk({rows[r].name, "_sd_pre"}, 5, SD, 8'd0);
      push_chk({rows[r].name, "_sd"},     6, SD, rows[r].hit ? bitv : 8'd0);
      push_chk({rows[r].name, "_mute"},   7, MU, {7'd0, rows[r].hit});
      if (rows[r].hit) begin
        push_chk({rows[r].name, "_sd_hold"}, 5 + SHDN, SD, bitv);
        push_chk({rows[r].name, "_sd_end"},  6 + SHDN, SD, 8'd0);
        push_chk({rows[r].name, "_mute_end"},7 + SHDN, MU, 8'd0);
      end
      fv = 2'b11;
      fv[rows[r].amp] = 1'b0;
      bus.Flt_n = fv;
      tick(rows[r].len);
      bus.Flt_n = 2'b11;
      tick(SHDN + 20 - rows[r].len);
      clr_pulse();
    end

    // Permanent fault on amp 1: three FLT periods then lockout.
    bus.Flt_n = 2'b01;
    push_chk("lk_f1_sd",   6,   SD,  8'd2);
    push_chk("lk_run1",    107, RDY, 8'd3);
    push_chk("lk_pre",     313, LK,  8'd0);
    push_chk("lk_pre_sd",  313, SD,  8'd2);
    push_chk("lk_on",      314, LK,  8'd2);
    push_chk("lk_on_sd",   314, SD,  8'd2);
    push_chk("lk_amp0",    314, RDY, 8'd1);
    push_chk("lk_hold",    400, LK,  8'd2);
    tick(420);
    bus.Flt_n = 2'b11;
    tick(10);
    push_chk("clr_pre_lk", 0, LK, 8'd2);
    bus.clr_flt = 1'b1;
    tick(1);
    bus.clr_flt = 1'b0;
    push_chk("clr_lk",      0,   LK, 8'd0);
    push_chk("clr_sd",      0,   SD, 8'd2);
    push_chk("clr_sd_hold", 99,  SD, 8'd2);
    push_chk("clr_sd_run",  100, SD, 8'd0);
    tick(120);

    // Two faults, a clean RUN long enough to clear the count, two more faults.
    bus.Flt_n = 2'b01;
    push_chk("rc_f2_sd", 110, SD,  8'd2);
    push_chk("rc_run2",  210, RDY, 8'd3);
    tick(111);
    bus.Flt_n = 2'b11;
    tick(209);
    bus.Flt_n = 2'b01;
    push_chk("rc_nolock1", 106, LK,  8'd0);
    push_chk("rc_run3",    106, RDY, 8'd3);
    push_chk("rc_f4_sd",   110, SD,  8'd2);
    tick(111);
    bus.Flt_n = 2'b11;
    push_chk("rc_run4",    99, RDY, 8'd3);
    push_chk("rc_nolock2", 99, LK,  8'd0);
    tick(110);

    // Reset asserted while amp 0 sits in FLT.
    bus.Flt_n = 2'b10;
    push_chk("rs_flt_sd", 10, SD, 8'd1);
    tick(20);
    rst_n = 1'b0;
    reset_checks("rs_mid");
    bus.Flt_n = 2'b11;
    tick(3);
    rst_n = 1'b1;
    powerup_checks("pu2");

    for (int k = 0; k < 2000 && sb.size() > 0; k++) tick(1);
    if (sb.size() > 0) begin
      $display("FAIL drain: %0d expectations still pending, required 0", sb.size());
      errors += sb.size();
      checks += sb.size();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
